main_memory: RTL and testbench
==============================

# main_memory

Main-memory responder at the far end of the cache-to-memory arbiter. It accepts one request at a time from the arbiter's memory-side outputs (load line, store line, or store word), models a fixed access latency, then returns a one-cycle response carrying the full line. The arbiter routes the response to whichever cache holds the grant, so this block is the single backing store for both instruction and data caches.

## Interface
- ADDRESS_WIDTH, 32: byte-address width.
- LINE_WIDTH, 128: cache-line width in bits; must be a multiple of 32 and a power of two.
- MEM_LINES, 1024: number of lines stored; power of two.
- MEM_LATENCY, 5: cycles from request acceptance to response; must be at least 1.

Ports (OFFSET = log2(LINE_WIDTH/8), IDX = log2(MEM_LINES)):
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- request_to_mem  in  1  request valid; held high by the arbiter until the response is seen.
- store_to_mem  in  1  1 = store, 0 = load.
- store_word_to_mem  in  1  with a store: 1 = write one 32-bit word, 0 = write the whole line.
- addr_to_mem  in  ADDRESS_WIDTH  byte address.
- data_to_mem  in  LINE_WIDTH  store data; word stores use bits [31:0].
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_data  out  LINE_WIDTH  line contents after the access; valid only while resp_valid is high.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Line index = addr[OFFSET+IDX-1:OFFSET]. Address bits above that range are ignored, so higher addresses alias onto lower lines. Offset bits below OFFSET are ignored, except that word select = addr[OFFSET-1:2].
- Array: MEM_LINES x LINE_WIDTH. Reset does not affect it. Simulation initialises it to all zero.
- State machine:
  - IDLE: if request_to_mem = 1 at an edge, latch store, store_word, address and data; load counter with MEM_LATENCY-1; go to BUSY.
  - BUSY: inputs are ignored. The counter decrements each edge. At the edge where counter = 0, perform the access, assert resp_valid and go to WAIT_LOW.
  - WAIT_LOW: resp_valid deasserts at the first edge. Stay until request_to_mem = 0 is sampled at an edge, then go to IDLE. This prevents a still-high request from being re-accepted.
- Access rules:
  - Load: resp_data = stored line.
  - Line store: stored line := latched data; resp_data = latched data.
  - Word store: only the 32-bit word at the word select is replaced, with data[31:0]. resp_data = merged line.
  - The array write and the resp_valid assertion happen at the same edge.
- Reset values: state IDLE, counter 0, resp_valid 0, resp_data 0, busy 0.
- Reset during BUSY aborts the access. No array write occurs and no response is produced.

## Timing
- Request accepted at edge E0. resp_valid is high for exactly one cycle, between edges E0+MEM_LATENCY and E0+MEM_LATENCY+1.
- busy rises after E0 and falls after the edge at which request_to_mem = 0 is sampled in WAIT_LOW.
- Minimum spacing between acceptances is MEM_LATENCY+2 edges, when the requester drops its request in the cycle resp_valid is high.
- Input changes after E0 have no effect on the access in flight.
- A request that is high and stable at E0 is always accepted. There is no back-pressure other than busy.
- Store followed by a load of the same line returns the stored data; there is no bypass hazard because accesses are strictly serial.

## Test plan
- Reset, then a load of 0x0000_0040 with request held: resp_valid pulses for one cycle exactly 5 cycles after acceptance. resp_data = 0 and busy = 1 throughout.
- Line store of 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D to 0x100, drop request, then load 0x10C: the load returns that line, and resp_data on the store response equals the written data.
- Word store of 0x11223344 to 0x108 over that line: the load returns 0xDEADBEEF_11223344_89ABCDEF_CAFEF00D, with only word 2 replaced.
- Request held high for 4 cycles after resp_valid: no second response occurs and busy stays high. After the drop, a new request is accepted on the next edge with the correct 5-cycle latency.
- reset_n pulsed low 2 cycles into a line store to 0x200: resp_valid never asserts, busy = 0 immediately, and a later load of 0x200 returns the prior contents.
- Aliasing: store to 0x200 + (MEM_LINES << OFFSET), then load 0x200: the stored data is returned. Also change addr and data while BUSY: the response reflects the values latched at acceptance.

Source files
------------

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module      : main_memory
// Description : Single backing store behind the cache-to-memory arbiter.
//               Accepts one load / line store / word store at a time, waits a
//               fixed latency, then returns the full line for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int MEM_LINES     = 1024,
    parameter int MEM_LATENCY   = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     request_to_mem,
    input  logic                     store_to_mem,
    input  logic                     store_word_to_mem,
    input  logic [ADDRESS_WIDTH-1:0] addr_to_mem,
    input  logic [LINE_WIDTH-1:0]    data_to_mem,
    output logic                     resp_valid,
    output logic [LINE_WIDTH-1:0]    resp_data,
    output logic                     busy
);

    localparam int c_OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int c_IDX    = $clog2(MEM_LINES);
    localparam int c_WORDS  = LINE_WIDTH / 32;
    localparam int c_WSEL_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LATENCY - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_BUSY     = 2'd1;
    localparam logic [1:0] c_WAIT_LOW = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_store;
    logic                  r_store_word;
    logic [c_IDX-1:0]      r_idx;
    logic [c_WSEL_W-1:0]   r_wsel;
    logic [LINE_WIDTH-1:0] r_data;

    // Storage array; deliberately outside the reset domain.
    logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];

    logic [c_WSEL_W-1:0]   w_wsel_in;
    logic [LINE_WIDTH-1:0] w_old_line;
    logic [LINE_WIDTH-1:0] w_merged;
    logic [LINE_WIDTH-1:0] w_resp_line;
    logic                  w_access;
    logic                  w_unused_addr;

    // Upper address bits alias and byte-offset bits are don't-care.
    assign w_unused_addr = ^addr_to_mem;

    generate
        if (c_WORDS > 1) begin : g_multi_word
            assign w_wsel_in = addr_to_mem[c_OFFSET-1:2];
        end else begin : g_single_word
            assign w_wsel_in = '0;
        end
    endgenerate

    assign w_access   = (r_state == c_BUSY) && (r_cnt == '0);
    assign w_old_line = r_mem[r_idx];
    assign busy       = (r_state != c_IDLE);

    // Splice the low 32 bits of the latched data into the selected word.
    always_comb begin
        w_merged = w_old_line;
        w_merged[32*int'(r_wsel) +: 32] = r_data[31:0];
    end

    // Line returned on the response: stored line, new line, or merged line.
    always_comb begin
        w_resp_line = w_old_line;
        if (r_store) begin
            w_resp_line = r_store_word ? w_merged : r_data;
        end
    end

    // Array write lands on the same edge that raises resp_valid.
    always_ff @(posedge clk) begin
        if (reset_n && w_access && r_store) begin
            r_mem[r_idx] <= w_resp_line;
        end
    end

    // Request sequencing: accept, count down the latency, respond, wait for drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_store      <= 1'b0;
            r_store_word <= 1'b0;
            r_idx        <= '0;
            r_wsel       <= '0;
            r_data       <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    resp_valid <= 1'b0;
                    if (request_to_mem) begin
                        r_store      <= store_to_mem;
                        r_store_word <= store_word_to_mem;
                        r_idx        <= addr_to_mem[c_OFFSET+c_IDX-1:c_OFFSET];
                        r_wsel       <= w_wsel_in;
                        r_data       <= data_to_mem;
                        r_cnt        <= c_CNT_LOAD;
                        r_state      <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (r_cnt == '0) begin
                        resp_valid <= 1'b1;
                        resp_data  <= w_resp_line;
                        r_state    <= c_WAIT_LOW;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                c_WAIT_LOW: begin
                    resp_valid <= 1'b0;
                    if (!request_to_mem) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory
// Description : Directed self-checking bench for main_memory with a
//               timestamp-based reference model of the backing store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory;

    localparam int LAT   = 5;
    localparam int LINES = 1024;

    localparam logic [127:0] L1  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] L1W = 128'hDEADBEEF_11223344_89ABCDEF_CAFEF00D;
    localparam logic [127:0] P0  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] L2  = 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA;
    localparam logic [127:0] L3  = 128'h0BADF00D_12345678_9ABCDEF0_0F1E2D3C;
    localparam logic [127:0] L4  = 128'hC0FFEE00_FACEB00C_13579BDF_2468ACE0;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         request_to_mem;
    logic         store_to_mem;
    logic         store_word_to_mem;
    logic [31:0]  addr_to_mem;
    logic [127:0] data_to_mem;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    main_memory #(
        .ADDRESS_WIDTH(32),
        .LINE_WIDTH   (128),
        .MEM_LINES    (LINES),
        .MEM_LATENCY  (LAT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .request_to_mem   (request_to_mem),
        .store_to_mem     (store_to_mem),
        .store_word_to_mem(store_word_to_mem),
        .addr_to_mem      (addr_to_mem),
        .data_to_mem      (data_to_mem),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .busy             (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [127:0] m_mem [LINES];
    int           cyc = 0;
    bit           m_active, m_done, m_valid;
    logic [127:0] m_data;
    int           m_due;
    bit           m_st, m_sw;
    logic [31:0]  m_a;
    logic [127:0] m_d;
    int           m_idx, m_ws;
    logic [127:0] m_line;

    always @(posedge clk) cyc <= cyc + 1;

    // Access is due LAT edges after the edge that saw the request.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0;
            m_done   = 0;
            m_valid  = 0;
        end else begin
            m_valid = 0;
            if (!m_active) begin
                if (request_to_mem) begin
                    m_active = 1;
                    m_done   = 0;
                    m_due    = cyc + LAT;
                    m_st     = store_to_mem;
                    m_sw     = store_word_to_mem;
                    m_a      = addr_to_mem;
                    m_d      = data_to_mem;
                end
            end else if (!m_done) begin
                if (cyc == m_due) begin
                    m_idx  = int'((m_a >> 4) % LINES);
                    m_ws   = int'((m_a >> 2) % 4);
                    m_line = m_mem[m_idx];
                    if (m_st) begin
                        if (m_sw) m_line[m_ws*32 +: 32] = m_d[31:0];
                        else      m_line = m_d;
                        m_mem[m_idx] = m_line;
                    end
                    m_data  = m_line;
                    m_valid = 1;
                    m_done  = 1;
                end
            end else if (!request_to_mem) begin
                m_active = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("busy", 128'(busy), 128'(m_active));
            check("resp_valid", 128'(resp_valid), 128'(m_valid));
            if (m_valid) check("resp_data", resp_data, m_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_access(input bit st, input bit sw, input logic [31:0] a,
                             input logic [127:0] d, input int hold, input bit scramble,
                             output logic [127:0] line, output int lat);
        bit got;
        int n;
        @(posedge clk);
        #1;
        request_to_mem    = 1'b1;
        store_to_mem      = st;
        store_word_to_mem = sw;
        addr_to_mem       = a;
        data_to_mem       = d;
        got  = 0;
        n    = 0;
        line = '0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            if (scramble && n == 2) begin
                #1;
                addr_to_mem       = a ^ 32'h0000_0300;
                data_to_mem       = ~d;
                store_to_mem      = ~st;
                store_word_to_mem = ~sw;
            end
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                got  = 1;
                line = resp_data;
            end
        end
        check("resp_timeout", 128'(got), 128'd1);
        lat = n - 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_no_resp", 128'(resp_valid), 128'd0);
            check("hold_busy", 128'(busy), 128'd1);
        end
        request_to_mem = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] line;
        int           lat;

        for (int i = 0; i < LINES; i++) m_mem[i] = '0;
        reset_n           = 1'b0;
        request_to_mem    = 1'b0;
        store_to_mem      = 1'b0;
        store_word_to_mem = 1'b0;
        addr_to_mem       = '0;
        data_to_mem       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 128'(resp_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_resp_data", resp_data, 128'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Load from never-written memory, request held through response.
        do_access(1'b0, 1'b0, 32'h0000_0040, '0, 0, 1'b0, line, lat);
        check("load40_latency", 128'(lat), 128'd5);
        check("load40_data", line, 128'd0);

        // Line store then load from a different offset in the same line.
        do_access(1'b1, 1'b0, 32'h0000_0100, L1, 0, 1'b0, line, lat);
        check("store100_resp", line, L1);
        do_access(1'b0, 1'b0, 32'h0000_010C, '0, 0, 1'b0, line, lat);
        check("load10C_data", line, L1);

        // Word store into word 2; upper data bits must be ignored.
        do_access(1'b1, 1'b1, 32'h0000_0108, {96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 32'h11223344},
                  0, 1'b0, line, lat);
        check("wstore108_resp", line, L1W);

        // Request held 4 cycles beyond the response, then re-request right away.
        do_access(1'b0, 1'b0, 32'h0000_0100, '0, 4, 1'b0, line, lat);
        check("load100_merged", line, L1W);
        check("load100_latency", 128'(lat), 128'd5);
        do_access(1'b0, 1'b0, 32'h0000_0104, '0, 0, 1'b0, line, lat);
        check("rereq_latency", 128'(lat), 128'd5);
        check("rereq_data", line, L1W);

        // Reset two cycles into a line store aborts it.
        do_access(1'b1, 1'b0, 32'h0000_0200, P0, 0, 1'b0, line, lat);
        check("store200_prior", line, P0);
        @(posedge clk);
        #1;
        request_to_mem = 1'b1;
        store_to_mem   = 1'b1;
        addr_to_mem    = 32'h0000_0200;
        data_to_mem    = L2;
        repeat (3) @(posedge clk);
        #1;
        reset_n        = 1'b0;
        request_to_mem = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_resp_valid", 128'(resp_valid), 128'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_resp", 128'(resp_valid), 128'd0);
        end
        do_access(1'b0, 1'b0, 32'h0000_0200, '0, 0, 1'b0, line, lat);
        check("abort_kept_prior", line, P0);

        // Aliasing: one full array span above 0x200 lands on the same line.
        do_access(1'b1, 1'b0, 32'h0000_0200 + (LINES << 4), L3, 0, 1'b0, line, lat);
        do_access(1'b0, 1'b0, 32'h0000_0200, '0, 0, 1'b0, line, lat);
        check("alias_load", line, L3);

        // Inputs scrambled while busy must not affect the access in flight.
        do_access(1'b1, 1'b0, 32'h0000_0300, L4, 0, 1'b1, line, lat);
        check("scramble_resp", line, L4);
        check("scramble_latency", 128'(lat), 128'd5);
        do_access(1'b0, 1'b0, 32'h0000_0300, '0, 0, 1'b0, line, lat);
        check("scramble_load300", line, L4);
        do_access(1'b0, 1'b0, 32'h0000_0000, '0, 0, 1'b0, line, lat);
        check("scramble_load000", line, 128'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
